axis_test_pattern_gen: RTL and testbench
========================================

AXIS_TEST_PATTERN_GEN -- requirements
Module: axis_test_pattern_gen

Interface
REQ-001 The block SHALL have parameter AXIS_DATA_WIDTH, default 8, giving the pixel data width.
REQ-002 The block SHALL have parameter IMG_WIDTH_MAX, default 16, giving the width of the column counter and i_width.
REQ-003 The block SHALL have parameter IMG_HEIGHT_MAX, default 16, giving the width of the row counter and i_height.
REQ-004 The block SHALL have port i_axi_clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port i_axi_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port i_enable, input, 1 bit: frame generation enable.
REQ-007 The block SHALL have port i_width, input, IMG_WIDTH_MAX bits: pixels per line.
REQ-008 The block SHALL have port i_height, input, IMG_HEIGHT_MAX bits: lines per frame.
REQ-009 The block SHALL have port i_pattern, input, 2 bits: pattern select.
REQ-010 The block SHALL have port i_blank_cycles, input, 32 bits: idle cycles between frames.
REQ-011 The block SHALL have ports o_axis_out_tuser, o_axis_out_tvalid and o_axis_out_tlast, output, 1 bit each, plus i_axis_out_tready, input, 1 bit: the AXI-Stream master handshake.
REQ-012 The block SHALL have port o_axis_out_tdata, output, AXIS_DATA_WIDTH bits: pixel data.
REQ-013 The block SHALL have port o_frame_count, output, 32 bits: number of frames completed.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high when not in IDLE.

Function
REQ-015 The state machine SHALL have three states: IDLE, ACTIVE and BLANK.
REQ-016 IDLE SHALL go to ACTIVE when i_enable=1, i_width!=0 and i_height!=0.
- On that transition, i_width, i_height and i_pattern are latched; the column and row counters x and y are cleared.
- If i_width or i_height is zero, the block SHALL remain in IDLE.
REQ-017 In ACTIVE, o_axis_out_tvalid SHALL be 1, and the block SHALL advance one beat per cycle with tvalid and tready both high.
REQ-018 While tvalid=1 and tready=0, tdata, tuser and tlast SHALL hold stable.
REQ-019 o_axis_out_tuser SHALL be 1 only on beat (x=0, y=0).
REQ-020 o_axis_out_tlast SHALL be 1 only on beats with x=width-1.
REQ-021 tdata SHALL be selected by the latched pattern value:
- 0: x
- 1: y
- 2: all-ones when x[3] XOR y[3] = 1, else zero
- 3: o_frame_count
REQ-022 Counter values SHALL be truncated or zero-extended to AXIS_DATA_WIDTH.
REQ-023 After an accepted tlast beat, x SHALL wrap to 0 and y SHALL increment.
REQ-024 The accepted beat with x=width-1 and y=height-1 SHALL end the frame:
- o_frame_count increments in the cycle after acceptance, wrapping at 2^32.
- The state goes to BLANK, or to IDLE if i_blank_cycles=0 and i_enable=0.
- With i_blank_cycles=0 and i_enable=1, the first beat of the next frame SHALL be presented in the next cycle.
REQ-025 BLANK SHALL hold tvalid=0 for exactly i_blank_cycles cycles, then apply the same start condition as IDLE; if the condition is false, the state goes to IDLE.
REQ-026 Deasserting i_enable mid-frame SHALL NOT truncate the frame; the frame completes, then the block returns to IDLE.
REQ-027 Changes to i_width, i_height or i_pattern mid-frame SHALL have no effect until the next frame start.
REQ-028 A 1x1 frame SHALL produce a single beat with tuser=1 and tlast=1.
REQ-029 tvalid SHALL be a registered output and SHALL NOT depend combinationally on tready.

Reset
REQ-030 Asserting i_axi_rst SHALL immediately force:
- state IDLE
- tvalid=0, tuser=0, tlast=0, tdata=0
- x=0, y=0
- o_frame_count=0, o_busy=0
- the blank counter to 0
REQ-031 Reset asserted mid-frame SHALL abandon the frame without incrementing o_frame_count.
REQ-032 After reset deassertion, the first frame SHALL start with tuser=1.

Structure
REQ-033 The pattern select codes (0-3) and the state encodings SHALL be constants in the shared video-stream package.
REQ-034 The block SHALL be a single module; no sub-module is required.

Verification
REQ-035 The bench SHALL cover: width=4, height=2, pattern=0, blank=3, tready=1 -> beats 0,1,2,3,0,1,2,3; tuser on beat 1 only; tlast on beats 4 and 8; 3 idle cycles; next tuser; o_frame_count=1.
REQ-036 The bench SHALL cover: random tready stalls of 0-5 cycles on an 8x4 frame, pattern=1 -> tdata/tuser/tlast stable during stalls; exactly 32 beats; each line's data equals its row number 0..3.
REQ-037 The bench SHALL cover: i_enable dropped at beat 5 of a 4x4 frame -> all 16 beats still sent; then IDLE with o_busy=0 and o_frame_count=1.
REQ-038 The bench SHALL cover: i_width=0, i_enable=1 -> tvalid stays 0 and o_busy stays 0 for 100 cycles.
REQ-039 The bench SHALL cover: reset asserted at beat 6 of a 4x4 frame -> tvalid=0 immediately and o_frame_count=0; after release, a fresh frame starts with tuser=1 and tdata=0.
REQ-040 The bench SHALL cover: a 1x1 frame with blank=0 and tready=1 -> a single beat with tuser=1 and tlast=1 in every cycle, o_frame_count incrementing every cycle; the output feeds the downstream frame counter, which reports 1 pixel per row and 1 line per frame.

Source files
------------

// File: rtl/axis_test_pattern_gen_pkg.sv
// Shared video-stream constants: FSM state encodings and pattern select codes
// used by the AXI-Stream test pattern generator.
package axis_test_pattern_gen_pkg;

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned PATTERN_W = 2;
  localparam int unsigned COUNT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } tpg_state_e;

  localparam logic [PATTERN_W-1:0] PAT_COLUMN  = 2'd0;
  localparam logic [PATTERN_W-1:0] PAT_ROW     = 2'd1;
  localparam logic [PATTERN_W-1:0] PAT_CHECKER = 2'd2;
  localparam logic [PATTERN_W-1:0] PAT_FRAME   = 2'd3;

endpackage

// File: rtl/axis_test_pattern_gen.sv
// AXI-Stream video test pattern generator.
// Emits frames of i_width x i_height pixels (tuser on the first pixel, tlast on
// the last pixel of each line), separated by i_blank_cycles idle cycles.
// Ports:
//   i_axi_clk, i_axi_rst       clock, asynchronous active-high reset
//   i_enable                   frame generation enable (sampled at frame start)
//   i_width, i_height          frame geometry, latched at frame start
//   i_pattern                  pattern select, latched at frame start
//   i_blank_cycles             idle cycles between frames
//   o_axis_out_*, i_axis_out_tready   AXI-Stream master
//   o_frame_count              completed frames (wraps at 2^32)
//   o_busy                     high whenever the FSM is not in IDLE
module axis_test_pattern_gen
  import axis_test_pattern_gen_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH_MAX   = 16,
  parameter int unsigned IMG_HEIGHT_MAX  = 16
) (
  input  logic                       i_axi_clk,
  input  logic                       i_axi_rst,
  input  logic                       i_enable,
  input  logic [IMG_WIDTH_MAX-1:0]   i_width,
  input  logic [IMG_HEIGHT_MAX-1:0]  i_height,
  input  logic [PATTERN_W-1:0]       i_pattern,
  input  logic [COUNT_W-1:0]         i_blank_cycles,
  output logic                       o_axis_out_tuser,
  output logic                       o_axis_out_tvalid,
  output logic                       o_axis_out_tlast,
  input  logic                       i_axis_out_tready,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
  output logic [COUNT_W-1:0]         o_frame_count,
  output logic                       o_busy
);

  tpg_state_e                 state, state_next;
  logic [IMG_WIDTH_MAX-1:0]   x, x_next;
  logic [IMG_HEIGHT_MAX-1:0]  y, y_next;
  logic [IMG_WIDTH_MAX-1:0]   width_lat, width_next;
  logic [IMG_HEIGHT_MAX-1:0]  height_lat, height_next;
  logic [PATTERN_W-1:0]       pattern_lat, pattern_next;
  logic [COUNT_W-1:0]         blank_cnt, blank_next;
  logic [COUNT_W-1:0]         count_next;
  logic                       valid_next, user_next, last_next, busy_next;
  logic [AXIS_DATA_WIDTH-1:0] data_next;
  logic                       start_ok, accept, last_x, last_y, begin_frame;

  // Next-state, counters and the next presented beat
  always_comb begin
    state_next   = state;
    x_next       = x;
    y_next       = y;
    width_next   = width_lat;
    height_next  = height_lat;
    pattern_next = pattern_lat;
    blank_next   = blank_cnt;
    count_next   = o_frame_count;
    begin_frame  = 1'b0;
    valid_next   = 1'b0;
    user_next    = 1'b0;
    last_next    = 1'b0;
    data_next    = '0;

    start_ok = i_enable && (i_width != '0) && (i_height != '0);
    accept   = o_axis_out_tvalid && i_axis_out_tready;
    last_x   = (x == width_lat - IMG_WIDTH_MAX'(1));
    last_y   = (y == height_lat - IMG_HEIGHT_MAX'(1));

    case (state)
      ST_IDLE: begin
        if (start_ok) begin_frame = 1'b1;
      end
      ST_ACTIVE: begin
        if (accept) begin
          if (last_x) begin
            x_next = '0;
            y_next = y + IMG_HEIGHT_MAX'(1);
            if (last_y) begin
              // Frame complete; enable is only consulted here, never mid-frame
              y_next     = '0;
              count_next = o_frame_count + COUNT_W'(1);
              if (i_blank_cycles != '0) begin
                state_next = ST_BLANK;
                blank_next = i_blank_cycles - COUNT_W'(1);
              end else if (start_ok) begin
                begin_frame = 1'b1;
              end else begin
                state_next = ST_IDLE;
              end
            end
          end else begin
            x_next = x + IMG_WIDTH_MAX'(1);
          end
        end
      end
      ST_BLANK: begin
        // blank_cnt holds the remaining idle cycles after this one
        if (blank_cnt != '0) begin
          blank_next = blank_cnt - COUNT_W'(1);
        end else if (start_ok) begin
          begin_frame = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (begin_frame) begin
      state_next   = ST_ACTIVE;
      x_next       = '0;
      y_next       = '0;
      width_next   = i_width;
      height_next  = i_height;
      pattern_next = i_pattern;
    end

    // Beat recomputed from unchanged x/y during a stall, so outputs hold stable
    valid_next = (state_next == ST_ACTIVE);
    busy_next  = (state_next != ST_IDLE);
    if (valid_next) begin
      user_next = (x_next == '0) && (y_next == '0);
      last_next = (x_next == width_next - IMG_WIDTH_MAX'(1));
      case (pattern_next)
        PAT_COLUMN:  data_next = AXIS_DATA_WIDTH'(x_next);
        PAT_ROW:     data_next = AXIS_DATA_WIDTH'(y_next);
        PAT_CHECKER: data_next = (x_next[3] ^ y_next[3]) ? '1 : '0;
        PAT_FRAME:   data_next = AXIS_DATA_WIDTH'(count_next);
        default:     data_next = '0;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      state             <= ST_IDLE;
      x                 <= '0;
      y                 <= '0;
      width_lat         <= '0;
      height_lat        <= '0;
      pattern_lat       <= '0;
      blank_cnt         <= '0;
      o_frame_count     <= '0;
      o_axis_out_tvalid <= 1'b0;
      o_axis_out_tuser  <= 1'b0;
      o_axis_out_tlast  <= 1'b0;
      o_axis_out_tdata  <= '0;
      o_busy            <= 1'b0;
    end else begin
      state             <= state_next;
      x                 <= x_next;
      y                 <= y_next;
      width_lat         <= width_next;
      height_lat        <= height_next;
      pattern_lat       <= pattern_next;
      blank_cnt         <= blank_next;
      o_frame_count     <= count_next;
      o_axis_out_tvalid <= valid_next;
      o_axis_out_tuser  <= user_next;
      o_axis_out_tlast  <= last_next;
      o_axis_out_tdata  <= data_next;
      o_busy            <= busy_next;
    end
  end

endmodule

// File: tb/tb_axis_test_pattern_gen.sv
// Self-checking bench for axis_test_pattern_gen: table of pattern vectors plus
// hand-written multi-cycle sequences (blanking, stalls, enable drop, reset).
module tb_axis_test_pattern_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned WM = 16;
  localparam int unsigned HM = 16;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [WM-1:0] width;
  logic [HM-1:0] height;
  logic [1:0]    pattern;
  logic [31:0]   blank_cycles;
  logic          tuser, tvalid, tlast, tready;
  logic [DW-1:0] tdata;
  logic [31:0]   frame_count;
  logic          busy;

  always #5 clk = ~clk;

  axis_test_pattern_gen #(
    .AXIS_DATA_WIDTH(DW),
    .IMG_WIDTH_MAX  (WM),
    .IMG_HEIGHT_MAX (HM)
  ) dut (
    .i_axi_clk        (clk),
    .i_axi_rst        (rst),
    .i_enable         (enable),
    .i_width          (width),
    .i_height         (height),
    .i_pattern        (pattern),
    .i_blank_cycles   (blank_cycles),
    .o_axis_out_tuser (tuser),
    .o_axis_out_tvalid(tvalid),
    .o_axis_out_tlast (tlast),
    .i_axis_out_tready(tready),
    .o_axis_out_tdata (tdata),
    .o_frame_count    (frame_count),
    .o_busy           (busy)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [DW-1:0] cap_data [512];
  logic          cap_user [512];
  logic          cap_last [512];
  int            cap_n;

  typedef struct {
    int         w;
    int         h;
    int         pat;
    int         idx;
    logic [7:0] data;
    logic       user;
    logic       last;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    tready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Start a frame and capture accepted beats until max_beats are seen.
  // Ends at the negedge where the last wanted beat is presented.
  task automatic run_frame(input int w, input int h, input int pat, input logic [31:0] blank,
                           input int drop_at, input bit stalls, input int max_beats);
    int            stall_left;
    logic          hold;
    logic [DW-1:0] hd;
    logic          hu, hl;
    cap_n = 0;
    stall_left = 0;
    hold = 1'b0;
    hd = '0;
    hu = 1'b0;
    hl = 1'b0;
    @(negedge clk);
    width = WM'(w);
    height = HM'(h);
    pattern = 2'(pat);
    blank_cycles = blank;
    enable = 1'b1;
    tready = 1'b1;
    for (int c = 0; c < 4000 && cap_n < max_beats; c++) begin
      @(negedge clk);
      if (tvalid && cap_n >= drop_at) enable = 1'b0;
      if (stalls) tready = (stall_left == 0);
      if (hold) begin
        check("stall hold tvalid", 32'(tvalid), 32'd1);
        check("stall hold tdata", 32'(tdata), 32'(hd));
        check("stall hold tuser/tlast", {30'd0, tuser, tlast}, {30'd0, hu, hl});
      end
      if (tvalid && tready) begin
        cap_data[cap_n] = tdata;
        cap_user[cap_n] = tuser;
        cap_last[cap_n] = tlast;
        cap_n++;
        hold = 1'b0;
        if (stalls) stall_left = $urandom_range(0, 5);
      end else begin
        if (stall_left > 0) stall_left--;
        hold = tvalid;
        hd = tdata;
        hu = tuser;
        hl = tlast;
      end
    end
    if (cap_n < max_beats) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL frame timeout: got %0d beats, expected %0d", cap_n, max_beats);
    end
  endtask

  initial begin
    int bad;
    int px, ln, row_px, frame_ln;
    logic [7:0] exp35 [8];

    rst = 1'b1;
    enable = 1'b0;
    width = '0;
    height = '0;
    pattern = '0;
    blank_cycles = '0;
    tready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset tvalid", 32'(tvalid), 32'd0);
    check("reset tuser/tlast", {30'd0, tuser, tlast}, 32'd0);
    check("reset tdata", 32'(tdata), 32'd0);
    check("reset frame_count", frame_count, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // w, h, pattern, beat index, data, tuser, tlast
    vecs[0]  = '{4,   2,  0, 0,   8'h00, 1'b1, 1'b0};
    vecs[1]  = '{4,   2,  0, 3,   8'h03, 1'b0, 1'b1};
    vecs[2]  = '{4,   2,  0, 7,   8'h03, 1'b0, 1'b1};
    vecs[3]  = '{4,   2,  1, 5,   8'h01, 1'b0, 1'b0};
    vecs[4]  = '{16,  1,  2, 7,   8'h00, 1'b0, 1'b0};
    vecs[5]  = '{16,  1,  2, 8,   8'hFF, 1'b0, 1'b0};
    vecs[6]  = '{1,   16, 2, 8,   8'hFF, 1'b0, 1'b1};
    vecs[7]  = '{16,  16, 2, 136, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{16,  16, 2, 24,  8'hFF, 1'b0, 1'b0};
    vecs[9]  = '{300, 1,  0, 258, 8'h02, 1'b0, 1'b0};
    vecs[10] = '{300, 1,  0, 299, 8'h2B, 1'b0, 1'b1};
    vecs[11] = '{2,   2,  3, 3,   8'h00, 1'b0, 1'b1};
    vecs[12] = '{1,   1,  1, 0,   8'h00, 1'b1, 1'b1};
    vecs[13] = '{3,   5,  1, 14,  8'h04, 1'b0, 1'b1};

    foreach (vecs[i]) begin
      do_reset();
      run_frame(vecs[i].w, vecs[i].h, vecs[i].pat, 32'd4, 0, 1'b0, vecs[i].w * vecs[i].h);
      check($sformatf("vec%0d tdata", i), 32'(cap_data[vecs[i].idx]), 32'(vecs[i].data));
      check($sformatf("vec%0d tuser", i), 32'(cap_user[vecs[i].idx]), 32'(vecs[i].user));
      check($sformatf("vec%0d tlast", i), 32'(cap_last[vecs[i].idx]), 32'(vecs[i].last));
    end

    // 4x2 column pattern, 3 blank cycles, back into a second frame
    do_reset();
    run_frame(4, 2, 0, 32'd3, NEVER, 1'b0, 8);
    exp35 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("4x2 beat%0d tdata", i), 32'(cap_data[i]), 32'(exp35[i]));
      check($sformatf("4x2 beat%0d tuser", i), 32'(cap_user[i]), (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("4x2 beat%0d tlast", i), 32'(cap_last[i]), (i == 3 || i == 7) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("4x2 blank%0d tvalid", i), 32'(tvalid), 32'd0);
      check($sformatf("4x2 blank%0d busy", i), 32'(busy), 32'd1);
      check($sformatf("4x2 blank%0d frame_count", i), frame_count, 32'd1);
    end
    @(negedge clk);
    check("4x2 next frame tvalid", 32'(tvalid), 32'd1);
    check("4x2 next frame tuser", 32'(tuser), 32'd1);
    check("4x2 next frame tdata", 32'(tdata), 32'd0);
    enable = 1'b0;

    // 8x4 row pattern with random stalls
    do_reset();
    run_frame(8, 4, 1, 32'd2, 0, 1'b1, 32);
    check("8x4 beat count", 32'(cap_n), 32'd32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (cap_data[i] !== DW'(i / 8)) bad++;
      if (cap_user[i] !== (i == 0)) bad++;
      if (cap_last[i] !== ((i % 8) == 7)) bad++;
    end
    check("8x4 row data/sideband errors", 32'(bad), 32'd0);
    tready = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tvalid) bad++;
    end
    check("8x4 extra beats", 32'(bad), 32'd0);

    // Enable dropped at beat 5 of a 4x4 frame
    do_reset();
    run_frame(4, 4, 0, 32'd0, 5, 1'b0, 16);
    check("enable drop beat count", 32'(cap_n), 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (cap_data[i] !== DW'(i % 4)) bad++;
    check("enable drop data errors", 32'(bad), 32'd0);
    repeat (3) @(negedge clk);
    check("enable drop busy", 32'(busy), 32'd0);
    check("enable drop tvalid", 32'(tvalid), 32'd0);
    check("enable drop frame_count", frame_count, 32'd1);

    // Zero width never starts
    do_reset();
    width = '0;
    height = HM'(4);
    blank_cycles = 32'd0;
    enable = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tvalid || busy) bad++;
    end
    check("zero width active cycles", 32'(bad), 32'd0);
    enable = 1'b0;

    // Reset at beat 6 of a 4x4 frame
    do_reset();
    run_frame(4, 4, 0, 32'd0, NEVER, 1'b0, 6);
    #2 rst = 1'b1;
    #1;
    check("mid-frame reset tvalid", 32'(tvalid), 32'd0);
    check("mid-frame reset frame_count", frame_count, 32'd0);
    check("mid-frame reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10 && !tvalid; c++) @(negedge clk);
    check("post-reset tvalid", 32'(tvalid), 32'd1);
    check("post-reset tuser", 32'(tuser), 32'd1);
    check("post-reset tdata", 32'(tdata), 32'd0);
    check("post-reset frame_count", frame_count, 32'd0);

    // 1x1 back-to-back frames with frame-count pattern and a downstream counter
    do_reset();
    width = WM'(1);
    height = HM'(1);
    pattern = 2'd3;
    blank_cycles = 32'd0;
    tready = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 10 && !tvalid; c++) @(negedge clk);
    px = 0;
    ln = 0;
    row_px = 0;
    frame_ln = 0;
    for (int n = 0; n < 10; n++) begin
      check($sformatf("1x1 beat%0d tvalid", n), 32'(tvalid), 32'd1);
      check($sformatf("1x1 beat%0d tuser/tlast", n), {30'd0, tuser, tlast}, 32'd3);
      check($sformatf("1x1 beat%0d tdata", n), 32'(tdata), 32'(DW'(n)));
      check($sformatf("1x1 beat%0d frame_count", n), frame_count, 32'(n));
      if (tvalid && tready) begin
        if (tuser) begin
          px = 0;
          ln = 0;
        end
        px++;
        if (tlast) begin
          row_px = px;
          px = 0;
          ln++;
          frame_ln = ln;
        end
      end
      @(negedge clk);
    end
    check("1x1 pixels per row", 32'(row_px), 32'd1);
    check("1x1 lines per frame", 32'(frame_ln), 32'd1);
    enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
